dds_sweep_ctrl: RTL and testbench

DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

---
 rtl/dds_pkg.sv | 17 +
 rtl/dds_sweep_ctrl_dwell_timer.sv | 23 ++
 rtl/dds_sweep_ctrl.sv | 149 ++++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared types and constants for the DDS sweep controller.
package dds_pkg;
  localparam int FREQ_W = 16;
  localparam logic [11:0] DC_MIDSCALE = 12'h800;

  typedef enum logic [2:0] {
    SINE = 3'd0, SQUARE = 3'd1, TRI = 3'd2, RAMP = 3'd3, DC = 3'd4
  } wave_sel_t;

  typedef enum logic [1:0] {
    MODE_SINGLE = 2'd0, MODE_CONT = 2'd1, MODE_UPDOWN = 2'd2
  } sweep_mode_t;

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_DWELL, S_STEP, S_FINISH
  } sweep_state_t;
endpackage

// File: rtl/dds_sweep_ctrl_dwell_timer.sv
// Dwell counter: counts sample ticks, flags the tick that completes the dwell.
module dds_dwell_timer #(
  parameter int DWELL_W = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               tick_en,
  input  logic [DWELL_W-1:0] limit,
  output logic               expired
);
  logic [DWELL_W-1:0] cnt, last;

  // A limit of zero dwells for a single tick, same as a limit of one.
  assign last    = (limit == '0) ? '0 : limit - DWELL_W'(1);
  assign expired = tick_en && (cnt == last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       cnt <= '0;
    else if (clr)     cnt <= '0;
    else if (tick_en) cnt <= expired ? '0 : cnt + DWELL_W'(1);
  end
endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency sweep sequencer driving a DDS core.
// Define DDS_SWEEP_UPDOWN_EN to enable bounce (up-down) mode.
module dds_sweep_ctrl #(
  parameter int FREQ_W  = dds_pkg::FREQ_W,
  parameter int DWELL_W = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sample_en,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [FREQ_W-1:0]  cfg_start,
  input  logic [FREQ_W-1:0]  cfg_stop,
  input  logic [FREQ_W-1:0]  cfg_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [2:0]         cfg_wave,
  input  logic [11:0]        cfg_dc,
  input  logic [1:0]         cfg_mode,
  input  logic               go,
  input  logic               abort,
  output logic [FREQ_W-1:0]  freq_word,
  output logic [2:0]         wave_sel,
  output logic [11:0]        dc_level,
  output logic               busy,
  output logic               done
);
  import dds_pkg::*;

  sweep_state_t       state, state_d;
  sweep_mode_t        mode_q;
  logic [FREQ_W-1:0]  start_q, stop_q, step_q, freq_d, ep, ep_n, stepped;
  logic [DWELL_W-1:0] dwell_q;
  logic [2:0]         wave_q;
  logic [11:0]        dc_q;
  logic [FREQ_W:0]    sum, diff;
  logic               xfer, load, expired, rev, rev_n, flip, up_n, at_end;

  assign xfer = cfg_valid && cfg_ready;

  dds_dwell_timer #(.DWELL_W(DWELL_W)) u_dwell (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state != S_DWELL),
    .tick_en (sample_en && state == S_DWELL),
    .limit   (dwell_q),
    .expired (expired)
  );

  // rev=1 means travelling back toward start after a bounce.
  assign ep     = rev ? start_q : stop_q;
  assign at_end = (freq_word == ep) || (step_q == '0);

`ifdef DDS_SWEEP_UPDOWN_EN
  assign flip = at_end && (mode_q == MODE_UPDOWN);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          rev <= 1'b0;
    else if (load)                       rev <= 1'b0;
    else if (state == S_STEP && !abort)  rev <= rev_n;
  end
`else
  assign flip = 1'b0;
  assign rev  = 1'b0;
`endif

  // The step after a bounce already heads toward the new endpoint.
  assign rev_n = rev ^ flip;
  assign ep_n  = rev_n ? start_q : stop_q;
  assign up_n  = (start_q <= stop_q) ^ rev_n;
  assign sum   = {1'b0, freq_word} + {1'b0, step_q};
  assign diff  = {1'b0, freq_word} - {1'b0, step_q};

  always_comb begin
    stepped = ep_n;
    if (up_n) begin
      if (sum < {1'b0, ep_n}) stepped = sum[FREQ_W-1:0];
    end else begin
      if (!diff[FREQ_W] && diff > {1'b0, ep_n}) stepped = diff[FREQ_W-1:0];
    end
  end

  always_comb begin
    state_d = state;
    freq_d  = freq_word;
    load    = 1'b0;
    case (state)
      S_IDLE, S_ARMED: begin
        if (xfer) state_d = S_ARMED;
        else if (go && state == S_ARMED) begin
          state_d = S_DWELL;
          freq_d  = start_q;
          load    = 1'b1;
        end
      end
      S_DWELL: if (expired) state_d = S_STEP;
      S_STEP: begin
        if (at_end && mode_q == MODE_SINGLE) state_d = S_FINISH;
        else begin
          state_d = S_DWELL;
          freq_d  = (at_end && !flip) ? start_q : stepped;
        end
      end
      S_FINISH: state_d = S_ARMED;
      default:  state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d = S_IDLE;
      freq_d  = freq_word;
      load    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      freq_word <= '0;
      wave_sel  <= DC;
      dc_level  <= DC_MIDSCALE;
      cfg_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      start_q   <= '0;
      stop_q    <= '0;
      step_q    <= '0;
      dwell_q   <= '0;
      wave_q    <= DC;
      dc_q      <= DC_MIDSCALE;
      mode_q    <= MODE_SINGLE;
    end else begin
      state     <= state_d;
      freq_word <= freq_d;
      cfg_ready <= (state_d == S_IDLE) || (state_d == S_ARMED);
      busy      <= (state_d == S_DWELL) || (state_d == S_STEP) || (state_d == S_FINISH);
      done      <= (state_d == S_FINISH);
      if (load) begin
        wave_sel <= wave_q;
        dc_level <= dc_q;
      end
      if (xfer && !abort) begin
        start_q <= cfg_start;
        stop_q  <= cfg_stop;
        step_q  <= cfg_step;
        dwell_q <= cfg_dwell;
        wave_q  <= cfg_wave;
        dc_q    <= cfg_dc;
        mode_q  <= sweep_mode_t'(cfg_mode);
      end
    end
  end
endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl: reset, sweep sequences, abort, corners.
module tb_dds_sweep_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0, sample_en = 1'b0, cfg_valid = 1'b0;
  logic        go = 1'b0, abort = 1'b0;
  logic        cfg_ready, busy, done;
  logic [15:0] cfg_start = '0, cfg_stop = '0, cfg_step = '0, freq_word;
  logic [19:0] cfg_dwell = '0;
  logic [2:0]  cfg_wave = '0, wave_sel;
  logic [11:0] cfg_dc = '0, dc_level;
  logic [1:0]  cfg_mode = '0;

  int          checks = 0, errors = 0, dones, cfg_bad;
  logic [15:0] seq[$];
  int          held[$];

  always #5 clk = ~clk;

  dds_sweep_ctrl dut (
    .clk(clk), .rst_n(rst_n), .sample_en(sample_en),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_step(cfg_step),
    .cfg_dwell(cfg_dwell), .cfg_wave(cfg_wave), .cfg_dc(cfg_dc),
    .cfg_mode(cfg_mode), .go(go), .abort(abort),
    .freq_word(freq_word), .wave_sel(wave_sel), .dc_level(dc_level),
    .busy(busy), .done(done)
  );

  task automatic configure(input logic [15:0] s, input logic [15:0] e, input logic [15:0] st,
                           input logic [19:0] dw, input logic [2:0] w, input logic [11:0] dc,
                           input logic [1:0] m);
    @(negedge clk);
    cfg_start = s; cfg_stop = e; cfg_step = st; cfg_dwell = dw;
    cfg_wave = w; cfg_dc = dc; cfg_mode = m; cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    checks++;
    if (cfg_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL configure: cfg_ready=%b busy=%b, want 1 0", cfg_ready, busy);
    end
  endtask

  task automatic start_sweep(input logic [15:0] f, input logic [2:0] w, input logic [11:0] dc);
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
    checks++;
    if (busy !== 1'b1 || freq_word !== f || wave_sel !== w || dc_level !== dc) begin
      errors++;
      $display("FAIL start: busy=%b freq=%0d wave=%0d dc=%h, want 1 %0d %0d %h",
               busy, freq_word, wave_sel, dc_level, f, w, dc);
    end
  endtask

  // Drives one sample tick every 4 clocks and records each distinct freq_word
  // with the number of ticks applied while it was held.
  task automatic watch(input int nvals, input bit until_done, input bit spam);
    bit fin = 1'b0;
    seq.delete(); held.delete(); dones = 0; cfg_bad = 0;
    for (int c = 0; c < 2000 && !fin; c++) begin
      if (done === 1'b1) dones++;
      if (spam && busy === 1'b1 && cfg_ready !== 1'b0) cfg_bad++;
      if (seq.size() == 0 || freq_word != seq[seq.size()-1]) begin
        seq.push_back(freq_word);
        held.push_back(0);
      end
      if (until_done ? (done === 1'b1) : (seq.size() >= nvals)) fin = 1'b1;
      else begin
        sample_en = (c % 4 == 0);
        if (sample_en) held[held.size()-1] = held[held.size()-1] + 1;
        @(negedge clk);
      end
    end
    sample_en = 1'b0;
    cfg_valid = 1'b0;
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL watch_timeout: sweep did not reach its end condition within 2000 clk");
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (freq_word !== 16'd0 || wave_sel !== 3'd4 || dc_level !== 12'h800) begin
      errors++;
      $display("FAIL reset_outputs: freq=%0d wave=%0d dc=%h, want 0 4 800", freq_word, wave_sel, dc_level);
    end
    checks++;
    if (cfg_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: ready=%b busy=%b done=%b, want 0 0 0", cfg_ready, busy, done);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: cfg_ready=%b, want 1", cfg_ready);
    end
  endtask

  task automatic test_go_in_idle();
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
    checks++;
    if (busy !== 1'b0 || freq_word !== 16'd0) begin
      errors++;
      $display("FAIL go_idle: busy=%b freq=%0d, want 0 0", busy, freq_word);
    end
  endtask

  task automatic test_single_up();
    logic [15:0] exp[4] = '{16'd1000, 16'd1100, 16'd1200, 16'd1300};
    configure(16'd1000, 16'd1300, 16'd100, 20'd4, 3'd1, 12'h123, 2'd0);
    start_sweep(16'd1000, 3'd1, 12'h123);
    watch(0, 1'b1, 1'b0);
    checks++;
    if (seq.size() != 4) begin errors++; $display("FAIL single_len: got %0d want 4", seq.size()); end
    for (int i = 0; i < 4 && i < seq.size(); i++) begin
      checks++;
      if (seq[i] !== exp[i] || held[i] != 4) begin
        errors++;
        $display("FAIL single_seq[%0d]: freq=%0d ticks=%0d, want %0d 4", i, seq[i], held[i], exp[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1 || freq_word !== 16'd1300 || dones != 1) begin
      errors++;
      $display("FAIL single_end: done=%b busy=%b ready=%b freq=%0d pulses=%0d, want 0 0 1 1300 1",
               done, busy, cfg_ready, freq_word, dones);
    end
  endtask

  task automatic test_sat_down();
    logic [15:0] exp[4] = '{16'd5000, 16'd4900, 16'd4800, 16'd4750};
    configure(16'd5000, 16'd4750, 16'd100, 20'd2, 3'd2, 12'h456, 2'd0);
    start_sweep(16'd5000, 3'd2, 12'h456);
    watch(0, 1'b1, 1'b0);
    checks++;
    if (seq.size() != 4) begin errors++; $display("FAIL down_len: got %0d want 4", seq.size()); end
    for (int i = 0; i < 4 && i < seq.size(); i++) begin
      checks++;
      if (seq[i] !== exp[i] || held[i] != 2) begin
        errors++;
        $display("FAIL down_seq[%0d]: freq=%0d ticks=%0d, want %0d 2", i, seq[i], held[i], exp[i]);
      end
    end
  endtask

  task automatic test_continuous();
    logic [15:0] exp[5] = '{16'd100, 16'd200, 16'd300, 16'd100, 16'd200};
    int late_done = 0;
    configure(16'd100, 16'd300, 16'd100, 20'd3, 3'd3, 12'h789, 2'd1);
    start_sweep(16'd100, 3'd3, 12'h789);
    watch(5, 1'b0, 1'b0);
    for (int i = 0; i < 5 && i < seq.size(); i++) begin
      checks++;
      if (seq[i] !== exp[i] || (i < 4 && held[i] != 3)) begin
        errors++;
        $display("FAIL cont_seq[%0d]: freq=%0d ticks=%0d, want %0d 3", i, seq[i], held[i], exp[i]);
      end
    end
    checks++;
    if (dones != 0) begin errors++; $display("FAIL cont_done: pulses=%0d want 0", dones); end
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || freq_word !== 16'd200 || done !== 1'b0 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort: busy=%b freq=%0d done=%b ready=%b, want 0 200 0 1", busy, freq_word, done, cfg_ready);
    end
    for (int i = 0; i < 10; i++) begin
      sample_en = (i % 2 == 0);
      @(negedge clk);
      if (done !== 1'b0 || freq_word !== 16'd200) late_done++;
    end
    sample_en = 1'b0;
    checks++;
    if (late_done != 0) begin errors++; $display("FAIL abort_hold: %0d bad cycles, want 0", late_done); end
  endtask

  task automatic test_updown();
`ifdef DDS_SWEEP_UPDOWN_EN
    logic [15:0] exp[6] = '{16'd100, 16'd200, 16'd300, 16'd200, 16'd100, 16'd200};
`else
    logic [15:0] exp[6] = '{16'd100, 16'd200, 16'd300, 16'd100, 16'd200, 16'd300};
`endif
    configure(16'd100, 16'd300, 16'd100, 20'd2, 3'd0, 12'h0ab, 2'd2);
    start_sweep(16'd100, 3'd0, 12'h0ab);
    watch(6, 1'b0, 1'b0);
    for (int i = 0; i < 6 && i < seq.size(); i++) begin
      checks++;
      if (seq[i] !== exp[i]) begin
        errors++;
        $display("FAIL updown_seq[%0d]: freq=%0d, want %0d", i, seq[i], exp[i]);
      end
    end
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
  endtask

  task automatic test_degenerate();
    configure(16'd2000, 16'd3000, 16'd0, 20'd0, 3'd4, 12'hfff, 2'd0);
    start_sweep(16'd2000, 3'd4, 12'hfff);
    watch(0, 1'b1, 1'b0);
    checks++;
    if (seq.size() != 1 || seq[0] !== 16'd2000 || held[0] != 1) begin
      errors++;
      $display("FAIL degenerate: values=%0d first=%0d ticks=%0d, want 1 2000 1", seq.size(), seq[0], held[0]);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL degenerate_end: busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_cfg_while_busy();
    logic [15:0] exp[4] = '{16'd1000, 16'd1100, 16'd1200, 16'd1300};
    configure(16'd1000, 16'd1300, 16'd100, 20'd4, 3'd1, 12'h321, 2'd0);
    start_sweep(16'd1000, 3'd1, 12'h321);
    cfg_start = 16'd7; cfg_stop = 16'd9; cfg_step = 16'd1; cfg_dwell = 20'd1;
    cfg_wave = 3'd3; cfg_dc = 12'h555; cfg_mode = 2'd1; cfg_valid = 1'b1;
    watch(0, 1'b1, 1'b1);
    checks++;
    if (cfg_bad != 0) begin errors++; $display("FAIL busy_ready: %0d cycles ready while busy, want 0", cfg_bad); end
    for (int i = 0; i < 4 && i < seq.size(); i++) begin
      checks++;
      if (seq[i] !== exp[i] || held[i] != 4) begin
        errors++;
        $display("FAIL busy_seq[%0d]: freq=%0d ticks=%0d, want %0d 4", i, seq[i], held[i], exp[i]);
      end
    end
    @(negedge clk);
    start_sweep(16'd1000, 3'd1, 12'h321);
  endtask

  task automatic test_reset_mid_sweep();
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (freq_word !== 16'd0 || busy !== 1'b0 || wave_sel !== 3'd4 || dc_level !== 12'h800) begin
      errors++;
      $display("FAIL async_reset: freq=%0d busy=%b wave=%0d dc=%h, want 0 0 4 800", freq_word, busy, wave_sel, dc_level);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
    checks++;
    if (busy !== 1'b0 || freq_word !== 16'd0) begin
      errors++;
      $display("FAIL reset_discard: busy=%b freq=%0d, want 0 0", busy, freq_word);
    end
  endtask

  initial begin
    test_reset();
    test_go_in_idle();
    test_single_up();
    test_sat_down();
    test_continuous();
    test_updown();
    test_degenerate();
    test_cfg_while_busy();
    test_reset_mid_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
